// File: rtl/host_link_ctrl.sv
// Host-side loader/unloader: buffers an upstream frame, bursts it into the core
// array, then captures the result stream into a FWFT FIFO for downstream.
module host_link_ctrl #(
    parameter int DATA_W  = 16,
    parameter int LOAD_AW = 10,
    parameter int RES_AW  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic [DATA_W-1:0] com_data_in,
    output logic              data_write_start,
    output logic              data_write_done,
    input  logic [DATA_W-1:0] com_data_out,
    input  logic              output_write_start,
    input  logic              output_write_done,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              frame_done,
    output logic              err_load_ovf,
    output logic              err_res_ovf,
    output logic              busy
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FILL  = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_BURST = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam logic [2:0] S_RECV  = 3'd5;
    localparam logic [LOAD_AW:0] ONE = 1;

    logic [2:0]         state;
    logic [DATA_W-1:0]  load_mem [2**LOAD_AW];
    logic [LOAD_AW:0]   wr_cnt, rd_cnt;
    logic [LOAD_AW-1:0] wr_addr;
    logic               accept, wr_full, load_we, last_word;

    logic [DATA_W-1:0]  res_mem [2**RES_AW];
    logic [RES_AW:0]    res_wp, res_rp;
    logic               res_empty, res_full, capture, pop, push;

    // wr_cnt holds the saturated frame length; bit LOAD_AW set means buffer full
    assign accept    = in_valid & in_ready;
    assign wr_full   = wr_cnt[LOAD_AW];
    assign wr_addr   = (state == S_IDLE) ? '0 : wr_cnt[LOAD_AW-1:0];
    assign load_we   = accept && (state == S_IDLE || !wr_full);
    assign last_word = (rd_cnt == wr_cnt - ONE);

    assign in_ready         = !rst && (state == S_IDLE || state == S_FILL);
    assign data_write_start = (state == S_START);
    assign data_write_done  = (state == S_BURST) && last_word;
    assign com_data_in      = (state == S_BURST) ? load_mem[rd_cnt[LOAD_AW-1:0]] : '0;
    assign busy             = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (load_we) load_mem[wr_addr] <= in_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            wr_cnt       <= '0;
            rd_cnt       <= '0;
            err_load_ovf <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                S_IDLE: if (accept) begin
                    wr_cnt <= ONE;
                    state  <= in_last ? S_START : S_FILL;
                end
                S_FILL: if (accept) begin
                    if (wr_full) err_load_ovf <= 1'b1;
                    else         wr_cnt       <= wr_cnt + ONE;
                    if (in_last) state <= S_START;
                end
                S_START: begin
                    rd_cnt <= '0;
                    state  <= S_BURST;
                end
                S_BURST: begin
                    if (last_word) state  <= S_WAIT;
                    else           rd_cnt <= rd_cnt + ONE;
                end
                S_WAIT: if (output_write_start) begin
                    if (output_write_done) begin
                        state      <= S_IDLE;
                        frame_done <= 1'b1;
                    end else begin
                        state <= S_RECV;
                    end
                end
                S_RECV: if (output_write_done) begin
                    state      <= S_IDLE;
                    frame_done <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // result FIFO: a same-cycle pop frees a slot for a push into a full FIFO
    assign capture   = (state == S_WAIT || state == S_RECV) && output_write_start && !output_write_done;
    assign res_empty = (res_wp == res_rp);
    assign res_full  = (res_wp[RES_AW] != res_rp[RES_AW]) &&
                       (res_wp[RES_AW-1:0] == res_rp[RES_AW-1:0]);
    assign out_valid = !res_empty;
    assign out_data  = res_mem[res_rp[RES_AW-1:0]];
    assign pop       = out_valid & out_ready;
    assign push      = capture && (!res_full || pop);

    always_ff @(posedge clk) begin
        if (push) res_mem[res_wp[RES_AW-1:0]] <= com_data_out;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_wp      <= '0;
            res_rp      <= '0;
            err_res_ovf <= 1'b0;
        end else begin
            if (push) res_wp <= res_wp + 1'b1;
            if (pop)  res_rp <= res_rp + 1'b1;
            if (capture && res_full && !pop) err_res_ovf <= 1'b1;
        end
    end
endmodule

// File: tb/tb_host_link_ctrl.sv
// Bench for host_link_ctrl: table of frame/result scenarios, random frames,
// and a reset-during-burst sequence, all checked against a queue-based model.
module tb_host_link_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_last, in_ready;
    logic [15:0] in_data, com_data_in, com_data_out, out_data;
    logic        data_write_start, data_write_done;
    logic        output_write_start, output_write_done;
    logic        out_valid, out_ready, frame_done, err_load_ovf, err_res_ovf, busy;

    host_link_ctrl #(.DATA_W(16), .LOAD_AW(10), .RES_AW(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .com_data_in(com_data_in), .data_write_start(data_write_start),
        .data_write_done(data_write_done), .com_data_out(com_data_out),
        .output_write_start(output_write_start), .output_write_done(output_write_done),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .frame_done(frame_done), .err_load_ovf(err_load_ovf), .err_res_ovf(err_res_ovf),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          len;
        logic [15:0] base;
        logic [15:0] step;
        int          res_n;
        int          res_mode;     // 0: out_ready low, 1: high, 2: random
        int          exp_burst;
        bit          exp_load_ovf;
        bit          exp_res_ovf;
    } vec_t;

    int          nvec = 0, nerr = 0;
    logic [15:0] fw[$];            // words of the frame being sent
    logic [15:0] rq[$];            // model of result FIFO contents
    bit          m_load_ovf = 0, m_res_ovf = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send_frame(input int len, input logic [15:0] base, input logic [15:0] step,
                              input bit rnd);
        logic [15:0] w;
        fw.delete();
        for (int i = 0; i < len; i++) begin
            w = rnd ? 16'($urandom) : 16'(base + 16'(i) * step);
            fw.push_back(w);
            @(negedge clk);
            in_valid = 1'b1; in_data = w; in_last = (i == len - 1);
            #1 chk("in_ready", in_ready, 1);
        end
        if (len > 1024) m_load_ovf = 1'b1;
    endtask

    task automatic check_burst(input int exp_burst);
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        #1;
        chk("start", data_write_start, 1);
        chk("in_ready_start", in_ready, 0);
        chk("busy_start", busy, 1);
        for (int k = 0; k < exp_burst; k++) begin
            @(negedge clk); #1;
            chk($sformatf("burst_w%0d", k), com_data_in, fw[k]);
            chk($sformatf("done_w%0d", k), data_write_done, (k == exp_burst - 1));
            chk("start_low", data_write_start, 0);
        end
        @(negedge clk); #1;
        chk("com_idle", com_data_in, 0);
        chk("done_low", data_write_done, 0);
        chk("busy_wait", busy, 1);
        chk("err_load_ovf", err_load_ovf, m_load_ovf);
    endtask

    // one cycle of the result FIFO model; caller has driven this cycle's inputs
    task automatic fifo_cycle(input bit cap, input logic [15:0] w);
        chk("out_valid", out_valid, rq.size() > 0);
        if (rq.size() > 0) chk("out_data", out_data, rq[0]);
        chk("err_res_ovf", err_res_ovf, m_res_ovf);
        if (out_ready && rq.size() > 0) void'(rq.pop_front());
        if (cap) begin
            if (rq.size() < 16) rq.push_back(w);
            else                m_res_ovf = 1'b1;
        end
    endtask

    task automatic run_results(input int n, input int mode, input bit rnd);
        logic [15:0] w;
        for (int i = 0; i < n; i++) begin
            w = rnd ? 16'($urandom) : 16'h0A000 + 16'(i);
            @(negedge clk);
            output_write_start = 1'b1; output_write_done = 1'b0; com_data_out = w;
            out_ready = (mode == 2) ? 1'($urandom) : (mode == 1);
            #1 fifo_cycle(1'b1, w);
        end
        @(negedge clk);
        output_write_start = 1'b1; output_write_done = 1'b1; com_data_out = 16'hDEAD;
        #1 fifo_cycle(1'b0, 16'h0);
        @(negedge clk);
        output_write_start = 1'b0; output_write_done = 1'b0; out_ready = 1'b1;
        #1;
        chk("frame_done", frame_done, 1);
        chk("busy_idle", busy, 0);
        fifo_cycle(1'b0, 16'h0);
        @(negedge clk); #1;
        chk("frame_done_pulse", frame_done, 0);
        fifo_cycle(1'b0, 16'h0);
        for (int t = 0; t < 40 && rq.size() > 0; t++) begin
            @(negedge clk); #1 fifo_cycle(1'b0, 16'h0);
        end
        @(negedge clk); #1;
        chk("drained", out_valid, 0);
        out_ready = 1'b0;
    endtask

    vec_t tbl[4];

    initial begin
        tbl[0] = '{4,    16'h0011, 16'h0011, 6,  1, 4,    1'b0, 1'b0};
        tbl[1] = '{1,    16'hBEEF, 16'h0000, 0,  1, 1,    1'b0, 1'b0};
        tbl[2] = '{3,    16'h1000, 16'h0001, 20, 0, 3,    1'b0, 1'b1};
        tbl[3] = '{1030, 16'h0000, 16'h0001, 2,  1, 1024, 1'b1, 1'b1};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        com_data_out = '0; output_write_start = 1'b0; output_write_done = 1'b0;
        out_ready = 1'b0;
        #12;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_start", data_write_start, 0);
        chk("rst_done", data_write_done, 0);
        chk("rst_com", com_data_in, 0);
        chk("rst_errs", {err_load_ovf, err_res_ovf, frame_done}, 0);
        @(negedge clk); rst = 1'b0;
        #1 chk("idle_in_ready", in_ready, 1);

        for (int v = 0; v < 4; v++) begin
            send_frame(tbl[v].len, tbl[v].base, tbl[v].step, 1'b0);
            check_burst(tbl[v].exp_burst);
            chk("tbl_load_ovf", err_load_ovf, tbl[v].exp_load_ovf);
            run_results(tbl[v].res_n, tbl[v].res_mode, 1'b0);
            chk("tbl_res_ovf", err_res_ovf, tbl[v].exp_res_ovf);
        end

        for (int r = 0; r < 6; r++) begin
            int len;
            len = int'($urandom_range(1, 40));
            send_frame(len, 16'h0, 16'h0, 1'b1);
            check_burst(len);
            run_results(int'($urandom_range(0, 24)), 2, 1'b1);
        end

        // reset asserted while the third burst word is on the bus
        send_frame(4, 16'h0100, 16'h0100, 1'b0);
        @(negedge clk); in_valid = 1'b0; in_last = 1'b0;
        #1 chk("rb_start", data_write_start, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1 chk("rb_word", com_data_in, fw[k]);
        end
        rst = 1'b1;
        #1;
        chk("rb_done", data_write_done, 0);
        chk("rb_busy", busy, 0);
        chk("rb_com", com_data_in, 0);
        chk("rb_errs", {err_load_ovf, err_res_ovf}, 0);
        m_load_ovf = 1'b0; m_res_ovf = 1'b0; rq.delete();
        @(negedge clk); rst = 1'b0;
        send_frame(2, 16'h5A5A, 16'h0101, 1'b0);
        check_burst(2);
        run_results(3, 1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
